// File: rtl/scalar_alu_pkg.sv
// Shared definitions for the scalar ALU and its requester arbiter.
package scalar_alu_pkg;

   // ALU op encodings; 100, 101 and 110 are reserved and reported as errors
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_SLL = 3'b011;
   localparam logic [2:0] OP_SRL = 3'b111;

   // Bit positions inside the 4-bit {N,Z,C,V} flag vector
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   // True for the reserved op codes
   function automatic logic is_illegal_op(input logic [2:0] op);
      return (op == 3'b100) || (op == 3'b101) || (op == 3'b110);
   endfunction

endpackage

// File: rtl/alu.sv
// Combinational scalar ALU: add, sub, low-half multiply and logical shifts.
module alu
   import scalar_alu_pkg::*;
#(
   parameter int N = 24
) (
   input  logic [2:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] result,
   output logic [3:0]   flags
);

   logic [N:0]   sum;
   logic [N:0]   diff;
   logic [N-1:0] prod;
   logic [4:0]   shamt;

   assign sum   = {1'b0, a} + {1'b0, b};
   assign diff  = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
   assign prod  = a * b;
   assign shamt = b[7:3];

   // Select the result and derive flags; shifts and reserved ops leave flags clear
   always_comb begin
      result = '0;
      flags  = '0;
      case (op)
         OP_ADD: begin
            result         = sum[N-1:0];
            flags[FLAG_N]  = sum[N-1];
            flags[FLAG_Z]  = (sum[N-1:0] == '0);
            flags[FLAG_C]  = sum[N];
            flags[FLAG_V]  = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
         end
         OP_SUB: begin
            result         = diff[N-1:0];
            flags[FLAG_N]  = diff[N-1];
            flags[FLAG_Z]  = (diff[N-1:0] == '0);
            flags[FLAG_C]  = diff[N];
            flags[FLAG_V]  = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
         end
         OP_MUL: begin
            result         = prod;
            flags[FLAG_N]  = prod[N-1];
            flags[FLAG_Z]  = (prod == '0);
         end
         OP_SLL:  result = a << shamt;
         OP_SRL:  result = a >> shamt;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/scalar_alu_arbiter_rr_grant.sv
// Round-robin picker: first valid requester at or above ptr, wrapping at NREQ.
module rr_grant #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IDW-1:0]  ptr,
   output logic [IDW-1:0]  grant_id,
   output logic            any
);

   int idx;

   // Scan NREQ positions starting at ptr; the first hit wins
   always_comb begin
      grant_id = '0;
      any      = 1'b0;
      idx      = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!any && valid[idx[IDW-1:0]]) begin
            any      = 1'b1;
            grant_id = idx[IDW-1:0];
         end
      end
   end

endmodule

// File: rtl/scalar_alu_arbiter.sv
// Shares one scalar ALU among NREQ requesters; one op in flight at a time.
module scalar_alu_arbiter
   import scalar_alu_pkg::*;
#(
   parameter int N    = 24,
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*3-1:0] req_op,
   input  logic [NREQ*N-1:0] req_a,
   input  logic [NREQ*N-1:0] req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [N-1:0]      rsp_result,
   output logic [3:0]        rsp_flags,
   output logic              rsp_err,
   output logic              busy
);

   arb_state_t     state, state_nxt;
   logic [IDW-1:0] ptr, ptr_nxt;
   logic [IDW-1:0] grant_id;
   logic           any;
   logic           accept;

   logic [2:0]     op_arr [NREQ];
   logic [N-1:0]   a_arr  [NREQ];
   logic [N-1:0]   b_arr  [NREQ];

   logic [2:0]     op_q;
   logic [N-1:0]   a_q, b_q;
   logic [IDW-1:0] id_q;

   logic [N-1:0]   alu_result;
   logic [3:0]     alu_flags;
   logic           op_err;

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign op_arr[i] = req_op[3*i +: 3];
      assign a_arr[i]  = req_a[N*i +: N];
      assign b_arr[i]  = req_b[N*i +: N];
   end

   rr_grant #(
      .NREQ     (NREQ),
      .IDW      (IDW)
   ) u_rr_grant (
      .valid    (req_valid),
      .ptr      (ptr),
      .grant_id (grant_id),
      .any      (any)
   );

   alu #(
      .N      (N)
   ) u_alu (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .result (alu_result),
      .flags  (alu_flags)
   );

   assign op_err    = is_illegal_op(op_q);
   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);

   // State and round-robin pointer; reset drops any in-flight op
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   // Next state, grant and pointer advance; ready is held low while reset is asserted
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      req_ready = '0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (any && rst) begin
               req_ready[grant_id] = 1'b1;
               accept              = 1'b1;
               state_nxt           = EXEC;
               ptr_nxt             = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
            end
         end
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture on grant; contents are don't-care outside EXEC
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q <= op_arr[grant_id];
         a_q  <= a_arr[grant_id];
         b_q  <= b_arr[grant_id];
         id_q <= grant_id;
      end
   end

   // Response registers load at the end of EXEC and hold through RESP
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_id     <= '0;
         rsp_result <= '0;
         rsp_flags  <= '0;
         rsp_err    <= 1'b0;
      end else if (state == EXEC) begin
         rsp_id     <= id_q;
         rsp_result <= op_err ? '1 : alu_result;
         rsp_flags  <= op_err ? 4'b0000 : alu_flags;
         rsp_err    <= op_err;
      end
   end

endmodule

// File: tb/tb_scalar_alu_arbiter.sv
// Directed bench for scalar_alu_arbiter with hand-computed expectations.
module tb_scalar_alu_arbiter;

   localparam int N    = 24;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*3-1:0] req_op;
   logic [NREQ*N-1:0] req_a;
   logic [NREQ*N-1:0] req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [N-1:0]      rsp_result;
   logic [3:0]        rsp_flags;
   logic              rsp_err;
   logic              busy;

   int checks = 0;
   int errors = 0;

   scalar_alu_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_flags  (rsp_flags),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
      req_valid[i]     = 1'b1;
      req_op[3*i +: 3] = op;
      req_a[N*i +: N]  = a;
      req_b[N*i +: N]  = b;
   endtask

   task automatic clr_req(input int i);
      req_valid[i] = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      @(posedge clk);
      #3 rst = 1'b1;
      tick();
   endtask

   // Single request with rsp_ready high; returns what was observed
   task automatic do_op(input int i, input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                        output logic [NREQ-1:0] rdy0, output int edges, output logic [IDW-1:0] rid,
                        output logic [N-1:0] res, output logic [3:0] fl, output logic er);
      rsp_ready = 1'b1;
      set_req(i, op, a, b);
      #1 rdy0 = req_ready;
      tick();
      clr_req(i);
      edges = 1;
      while (!rsp_valid && edges < 10) begin
         tick();
         edges++;
      end
      rid = rsp_id;
      res = rsp_result;
      fl  = rsp_flags;
      er  = rsp_err;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (rsp_valid !== 1'b0)  begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
      checks++; if (rsp_id !== 2'd0)     begin errors++; $display("FAIL reset_rsp_id got %0d exp 0", rsp_id); end
      checks++; if (rsp_result !== '0)   begin errors++; $display("FAIL reset_rsp_result got %h exp 000000", rsp_result); end
      checks++; if (rsp_flags !== 4'b0)  begin errors++; $display("FAIL reset_rsp_flags got %b exp 0000", rsp_flags); end
      checks++; if (rsp_err !== 1'b0)    begin errors++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
      checks++; if (req_ready !== 4'b0)  begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      #2 rst = 1'b1;
      tick();
   endtask

   task automatic test_add();
      logic [NREQ-1:0] rdy; int e; logic [IDW-1:0] id; logic [N-1:0] r; logic [3:0] f; logic er;
      do_op(1, 3'b000, 24'd5, 24'd3, rdy, e, id, r, f, er);
      checks++; if (rdy !== 4'b0010)  begin errors++; $display("FAIL add_ready got %b exp 0010", rdy); end
      checks++; if (e !== 2)          begin errors++; $display("FAIL add_latency got %0d exp 2", e); end
      checks++; if (id !== 2'd1)      begin errors++; $display("FAIL add_id got %0d exp 1", id); end
      checks++; if (r !== 24'h000008) begin errors++; $display("FAIL add_result got %h exp 000008", r); end
      checks++; if (f !== 4'b0000)    begin errors++; $display("FAIL add_flags got %b exp 0000", f); end
      checks++; if (er !== 1'b0)      begin errors++; $display("FAIL add_err got %b exp 0", er); end
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0)
         begin errors++; $display("FAIL add_idle got valid=%b busy=%b exp 0 0", rsp_valid, busy); end
   endtask

   task automatic test_sub();
      logic [NREQ-1:0] rdy; int e; logic [IDW-1:0] id; logic [N-1:0] r; logic [3:0] f; logic er;
      do_op(0, 3'b001, 24'd3, 24'd3, rdy, e, id, r, f, er);
      checks++; if (r !== 24'h000000) begin errors++; $display("FAIL sub_eq_result got %h exp 000000", r); end
      checks++; if (f !== 4'b0110)    begin errors++; $display("FAIL sub_eq_flags got %b exp 0110", f); end
      checks++; if (id !== 2'd0)      begin errors++; $display("FAIL sub_eq_id got %0d exp 0", id); end
      do_op(0, 3'b001, 24'd2, 24'd5, rdy, e, id, r, f, er);
      checks++; if (r !== 24'hFFFFFD) begin errors++; $display("FAIL sub_neg_result got %h exp fffffd", r); end
      checks++; if (f !== 4'b1000)    begin errors++; $display("FAIL sub_neg_flags got %b exp 1000", f); end
   endtask

   task automatic test_boundaries();
      logic [NREQ-1:0] rdy; int e; logic [IDW-1:0] id; logic [N-1:0] r; logic [3:0] f; logic er;
      do_op(2, 3'b000, 24'h7FFFFF, 24'd1, rdy, e, id, r, f, er);
      checks++; if (r !== 24'h800000 || f !== 4'b1001)
         begin errors++; $display("FAIL add_ovf got %h/%b exp 800000/1001", r, f); end
      do_op(2, 3'b000, 24'hFFFFFF, 24'd1, rdy, e, id, r, f, er);
      checks++; if (r !== 24'h000000 || f !== 4'b0110)
         begin errors++; $display("FAIL add_carry got %h/%b exp 000000/0110", r, f); end
      do_op(3, 3'b010, 24'd3, 24'd5, rdy, e, id, r, f, er);
      checks++; if (r !== 24'h00000F) begin errors++; $display("FAIL mul_small got %h exp 00000f", r); end
      do_op(3, 3'b010, 24'h001000, 24'h001000, rdy, e, id, r, f, er);
      checks++; if (r !== 24'h000000) begin errors++; $display("FAIL mul_trunc got %h exp 000000", r); end
      do_op(1, 3'b011, 24'd1, 24'h000028, rdy, e, id, r, f, er);
      checks++; if (r !== 24'h000020 || f !== 4'b0000)
         begin errors++; $display("FAIL sll got %h/%b exp 000020/0000", r, f); end
      do_op(1, 3'b011, 24'd1, 24'hFFFF08, rdy, e, id, r, f, er);
      checks++; if (r !== 24'h000002) begin errors++; $display("FAIL sll_shamt_bits got %h exp 000002", r); end
   endtask

   task automatic test_round_robin();
      int grants [$];
      int ids [$];
      logic [N-1:0] results [$];
      apply_reset();
      rsp_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) set_req(i, 3'b000, N'(i + 1), 24'd10);
      #1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         checks++; if ($countones(req_ready) > 1)
            begin errors++; $display("FAIL rr_onehot got %b exp at most one bit", req_ready); end
         for (int i = 0; i < NREQ; i++) if (req_ready[i]) grants.push_back(i);
         if (rsp_valid) begin ids.push_back(int'(rsp_id)); results.push_back(rsp_result); end
         tick();
      end
      req_valid = '0;
      for (int n = 0; n < 10 && busy; n++) tick();
      checks++; if (grants.size() < 8 || ids.size() < 8)
         begin errors++; $display("FAIL rr_count got %0d grants %0d rsps exp >=8", grants.size(), ids.size()); end
      else begin
         for (int k = 0; k < 8; k++) begin
            checks++; if (grants[k] != k % NREQ)
               begin errors++; $display("FAIL rr_grant[%0d] got %0d exp %0d", k, grants[k], k % NREQ); end
            checks++; if (ids[k] != k % NREQ)
               begin errors++; $display("FAIL rr_rsp_id[%0d] got %0d exp %0d", k, ids[k], k % NREQ); end
            checks++; if (results[k] !== N'(k % NREQ + 11))
               begin errors++; $display("FAIL rr_result[%0d] got %h exp %h", k, results[k], N'(k % NREQ + 11)); end
         end
      end
   endtask

   task automatic test_backpressure();
      rsp_ready = 1'b0;
      set_req(2, 3'b111, 24'h000080, 24'h000018);
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant got %b exp 0100", req_ready); end
      tick();
      clr_req(2);
      set_req(0, 3'b000, 24'd1, 24'd1);
      #1;
      checks++; if (req_ready !== 4'b0000 || busy !== 1'b1)
         begin errors++; $display("FAIL bp_exec got ready=%b busy=%b exp 0000 1", req_ready, busy); end
      tick();
      for (int k = 0; k < 5; k++) begin
         checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 24'h000010 ||
                       rsp_flags !== 4'b0000 || rsp_err !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1)
            begin errors++; $display("FAIL bp_hold[%0d] got v=%b id=%0d r=%h f=%b e=%b rdy=%b exp 1 2 000010 0000 0 0000",
                                     k, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, req_ready); end
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_same_cycle got %b exp 0000", req_ready); end
      tick();
      checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0001)
         begin errors++; $display("FAIL bp_after_hs got v=%b rdy=%b exp 0 0001", rsp_valid, req_ready); end
      tick();
      clr_req(0);
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 24'd2)
         begin errors++; $display("FAIL bp_next got v=%b id=%0d r=%h exp 1 0 000002", rsp_valid, rsp_id, rsp_result); end
      tick();
   endtask

   task automatic test_illegal_wrap();
      logic [NREQ-1:0] rdy; int e; logic [IDW-1:0] id; logic [N-1:0] r; logic [3:0] f; logic er;
      do_op(3, 3'b100, 24'd1, 24'd2, rdy, e, id, r, f, er);
      checks++; if (r !== 24'hFFFFFF || f !== 4'b0000 || er !== 1'b1 || id !== 2'd3)
         begin errors++; $display("FAIL illegal got r=%h f=%b e=%b id=%0d exp ffffff 0000 1 3", r, f, er, id); end
      set_req(0, 3'b000, 24'd4, 24'd4);
      set_req(1, 3'b000, 24'd7, 24'd7);
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_grant got %b exp 0001", req_ready); end
      tick();
      clr_req(0); clr_req(1);
      tick();
      checks++; if (rsp_id !== 2'd0 || rsp_result !== 24'd8 || rsp_err !== 1'b0)
         begin errors++; $display("FAIL wrap_rsp got id=%0d r=%h e=%b exp 0 000008 0", rsp_id, rsp_result, rsp_err); end
      tick();
   endtask

   task automatic test_async_reset();
      rsp_ready = 1'b1;
      set_req(1, 3'b000, 24'd9, 24'd9);
      tick();
      clr_req(1);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ar_exec got busy=%b exp 1", busy); end
      #2 rst = 1'b0;
      set_req(2, 3'b000, 24'd1, 24'd1);
      #1;
      checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_result !== '0 ||
                    rsp_flags !== 4'b0 || rsp_err !== 1'b0 || req_ready !== 4'b0)
         begin errors++; $display("FAIL ar_clear got b=%b v=%b id=%0d r=%h f=%b e=%b rdy=%b exp all 0",
                                  busy, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, req_ready); end
      clr_req(2);
      @(posedge clk);
      #3 rst = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) begin
         checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL ar_no_rsp[%0d] got v=%b b=%b exp 0 0", k, rsp_valid, busy); end
         tick();
      end
      set_req(3, 3'b000, 24'd6, 24'd6);
      set_req(1, 3'b000, 24'd2, 24'd3);
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL ar_ptr got %b exp 0010", req_ready); end
      tick();
      clr_req(3); clr_req(1);
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== 24'd5)
         begin errors++; $display("FAIL ar_after got v=%b id=%0d r=%h exp 1 1 000005", rsp_valid, rsp_id, rsp_result); end
      tick();
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_boundaries();
      test_round_robin();
      test_backpressure();
      test_illegal_wrap();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
